// File: rtl/orb_descriptor_packer_if.sv
// Descriptor packer bundle: core-side capture inputs plus the 32-bit packet stream.
// Latency: none, wires only.
// Backpressure: out_ready throttles the stream; the core side has no ready.
//
// master: the packer (consumes ena/descriptors/in_valid/out_ready, drives out_*)
// slave : the environment (core plus host/DMA side)
interface orb_descriptor_packer_if;
    logic         ena;
    logic [255:0] descriptors;
    logic         in_valid;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (
        input  ena, descriptors, in_valid, out_ready,
        output out_data, out_valid, out_last
    );

    modport slave (
        output ena, descriptors, in_valid, out_ready,
        input  out_data, out_valid, out_last
    );
endinterface

// File: rtl/orb_descriptor_packer.sv
// Tags each rBRIEF descriptor with its raster position, queues it and emits 9-word packets.
// Latency: push at edge N gives the header at edge N+1; 10 cycles per packet sustained.
// Backpressure: out_ready stalls the stream; a full queue drops input and sets overflow.
//
// Ports: clk, rst (async active-low), bus (orb_descriptor_packer_if.master),
//        overflow (sticky drop flag), drop_count (saturating drop counter).
// Optional feature macro: ORB_PACKER_STATS_EN enables drop_count, otherwise it is tied to 0.
module orb_descriptor_packer #(
    parameter int IMG_WIDTH         = 640,
    parameter int IMG_HEIGHT        = 480,
    parameter int WIDTH_DESCRIPTORS = 256,
    parameter int DEPTH             = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    orb_descriptor_packer_if.master     bus,
    output logic                        overflow,
    output logic [15:0]                 drop_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]                  tag;
        logic [WIDTH_DESCRIPTORS-1:0] desc;
    } entry_t;

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    logic [15:0]                  col;
    logic [15:0]                  row;
    entry_t                       mem [DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [CW-1:0]                count;
    state_t                       state;
    logic [2:0]                   idx;
    logic [2:0]                   idx_n;
    logic [WIDTH_DESCRIPTORS-1:0] desc_q;
    logic                         full;
    logic                         empty;
    logic                         push;
    logic                         drop;
    logic                         pop;

    // Occupancy is judged at the start of the cycle: a pop this cycle never
    // makes room for a push this cycle.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.ena && bus.in_valid && !full;
    assign drop  = bus.ena && bus.in_valid && full;
    // The head entry stays in the queue until its last body word is taken,
    // so the packet in flight still counts toward occupancy.
    assign pop   = (state == BODY) && bus.out_ready && (idx == 3'd7);
    assign idx_n = idx + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.ena) begin
            if (col == 16'(IMG_WIDTH - 1)) begin
                col <= '0;
                row <= (row == 16'(IMG_HEIGHT - 1)) ? '0 : row + 16'd1;
            end else begin
                col <= col + 16'd1;
            end
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{tag: {row, col}, desc: bus.descriptors};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef ORB_PACKER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign drop_count = '0;
`endif

    // Output stream: all outputs registered, so out_ready never reaches them
    // combinationally. Words hold while out_ready is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            desc_q        <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        desc_q        <= mem[rd_ptr].desc;
                        bus.out_data  <= mem[rd_ptr].tag;
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= 1'b0;
                        state         <= HDR;
                    end
                end
                HDR: begin
                    if (bus.out_ready) begin
                        idx          <= '0;
                        bus.out_data <= desc_q[31:0];
                        bus.out_last <= 1'b0;
                        state        <= BODY;
                    end
                end
                BODY: begin
                    if (bus.out_ready) begin
                        if (idx == 3'd7) begin
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            idx          <= idx_n;
                            bus.out_data <= desc_q[{idx_n, 5'd0} +: 32];
                            bus.out_last <= (idx_n == 3'd7);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_orb_descriptor_packer.sv
// Bench for orb_descriptor_packer: table-driven single packet plus directed multi-cycle sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven constant or pseudo-random depending on the sequence.
module tb_orb_descriptor_packer;
    localparam int W = 16;
    localparam int H = 4;
    localparam int D = 4;
`ifdef ORB_PACKER_STATS_EN
    localparam logic [15:0] EXP_DROP2 = 16'd2;
    localparam logic [15:0] EXP_DROP1 = 16'd1;
`else
    localparam logic [15:0] EXP_DROP2 = 16'd0;
    localparam logic [15:0] EXP_DROP1 = 16'd0;
`endif

    typedef struct {
        logic        ena;
        logic        iv;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        el;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        overflow;
    logic [15:0] drop_count;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    vec_t        tbl[17];

    always #5 clk = ~clk;

    orb_descriptor_packer_if bus();

    orb_descriptor_packer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .WIDTH_DESCRIPTORS(256), .DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .overflow(overflow), .drop_count(drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.ena = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.descriptors = '0;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
    endtask

    function automatic logic [255:0] mk_desc(input logic [7:0] seed);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = {8'hD0, seed, 8'h00, 8'(i)};
        return d;
    endfunction

    task automatic expect_pkt(input logic [31:0] tag, input logic [255:0] d);
        exp_q.push_back(tag);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[32*i +: 32]);
    endtask

    task automatic push(input logic [255:0] d);
        bus.ena = 1'b1; bus.in_valid = 1'b1; bus.descriptors = d;
        tick();
        bus.ena = 1'b0; bus.in_valid = 1'b0;
    endtask

    task automatic run_ena(input int n);
        bus.ena = 1'b1; bus.in_valid = 1'b0;
        repeat (n) tick();
        bus.ena = 1'b0;
    endtask

    // Consumes the expected word queue, checking order, out_last position and
    // that data/last hold steady across stalls.
    task automatic drain(input bit rnd, input int budget);
        int          n = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [31:0] held_d = '0;
        logic        held_l = 1'b0;
        logic [31:0] e;
        while (exp_q.size() > 0 && cyc < budget) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid) begin
                if (stalled) begin
                    check("stall_hold_data", bus.out_data, held_d);
                    check("stall_hold_last", {31'b0, bus.out_last}, {31'b0, held_l});
                end
                if (bus.out_ready) begin
                    e = exp_q.pop_front();
                    check("word", bus.out_data, e);
                    check("last", {31'b0, bus.out_last}, {31'b0, (n % 9) == 8});
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = bus.out_data;
                    held_l  = bus.out_last;
                end
            end else begin
                stalled = 1'b0;
            end
            tick();
            cyc++;
        end
        check("drain_words_left", 32'(exp_q.size()), 32'd0);
        bus.out_ready = 1'b1;
    endtask

    task automatic quiet(input int n);
        int seen = 0;
        repeat (n) begin
            if (bus.out_valid) seen++;
            tick();
        end
        check("quiet_no_extra_words", 32'(seen), 32'd0);
    endtask

    initial begin
        logic [255:0] d1;
        logic [255:0] d0;

        // Reset state
        bus.ena = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.descriptors = '0;
        rst = 1'b0;
        tick(); tick();
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_last", {31'b0, bus.out_last}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_drop_count", {16'b0, drop_count}, 32'd0);
        rst = 1'b1;
        tick();

        // Single descriptor at col 5: table of per-cycle inputs and expected outputs
        for (int k = 0; k < 32; k++) d1[8*k +: 8] = 8'(k + 1);
        for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b0};
        for (int w = 0; w < 8; w++)
            tbl[7 + w] = '{1'b0, 1'b0, 1'b1, 1'b1, d1[32*w +: 32], (w == 7)};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
        bus.descriptors = d1;
        for (int i = 0; i < 17; i++) begin
            bus.ena = tbl[i].ena; bus.in_valid = tbl[i].iv; bus.out_ready = tbl[i].rdy;
            tick();
            check($sformatf("tbl%0d_valid", i), {31'b0, bus.out_valid}, {31'b0, tbl[i].ev});
            check($sformatf("tbl%0d_last", i), {31'b0, bus.out_last}, {31'b0, tbl[i].el});
            if (tbl[i].ev) check($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].ed);
        end

        // Raster wrap: W+3 enabled cycles then a push tags {row=1,col=3}
        do_reset();
        run_ena(W + 3);
        push(mk_desc(8'h11));
        expect_pkt(32'h0001_0003, mk_desc(8'h11));
        drain(1'b0, 100);
        // 20 cycles used so far; 46 more lands on 66 = one full frame + col 2, row 0
        run_ena(46);
        push(mk_desc(8'h22));
        expect_pkt(32'h0000_0002, mk_desc(8'h22));
        drain(1'b0, 100);
        // ena gating: in_valid alone neither pushes nor advances the counters
        bus.ena = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ena_gate_no_push", {31'b0, bus.out_valid}, 32'd0);
        end
        bus.in_valid = 1'b0;
        push(mk_desc(8'h33));
        expect_pkt(32'h0000_0003, mk_desc(8'h33));
        drain(1'b0, 100);
        quiet(5);

        // Back-pressure: three queued packets, random out_ready
        do_reset();
        push(mk_desc(8'hA0));
        push(mk_desc(8'hA1));
        push(mk_desc(8'hA2));
        expect_pkt(32'h0000_0000, mk_desc(8'hA0));
        expect_pkt(32'h0000_0001, mk_desc(8'hA1));
        expect_pkt(32'h0000_0002, mk_desc(8'hA2));
        drain(1'b1, 600);
        quiet(15);

        // Overflow: DEPTH+2 pushes with out_ready low
        do_reset();
        for (int i = 0; i < D + 2; i++) push(mk_desc(8'(8'hB0 + i)));
        check("ovf_flag", {31'b0, overflow}, 32'd1);
        check("ovf_drop_count", {16'b0, drop_count}, {16'b0, EXP_DROP2});
        for (int i = 0; i < D; i++) expect_pkt(32'(i), mk_desc(8'(8'hB0 + i)));
        drain(1'b0, 200);
        quiet(20);
        check("ovf_sticky", {31'b0, overflow}, 32'd1);

        // Full queue, final body handshake coincides with an incoming descriptor
        do_reset();
        d0 = mk_desc(8'hC0);
        push(d0);
        for (int i = 1; i < D; i++) push(mk_desc(8'(8'hC0 + i)));
        bus.out_ready = 1'b1;
        repeat (8) tick();
        check("fullpop_last", {31'b0, bus.out_last}, 32'd1);
        check("fullpop_word7", bus.out_data, d0[255:224]);
        check("fullpop_no_ovf_yet", {31'b0, overflow}, 32'd0);
        bus.ena = 1'b1; bus.in_valid = 1'b1; bus.descriptors = mk_desc(8'hEE);
        tick();
        bus.ena = 1'b0; bus.in_valid = 1'b0;
        check("fullpop_ovf", {31'b0, overflow}, 32'd1);
        check("fullpop_drop_count", {16'b0, drop_count}, {16'b0, EXP_DROP1});
        check("fullpop_idle", {31'b0, bus.out_valid}, 32'd0);
        for (int i = 1; i < D; i++) expect_pkt(32'(i), mk_desc(8'(8'hC0 + i)));
        drain(1'b0, 200);
        quiet(20);

        // Reset mid-packet aborts the packet and discards queued entries
        do_reset();
        push(mk_desc(8'hF0));
        push(mk_desc(8'hF1));
        bus.out_ready = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_last", {31'b0, bus.out_last}, 32'd0);
        check("midrst_data", bus.out_data, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        quiet(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/orb_descriptor_packer.md
# orb_descriptor_packer

Output stage directly downstream of the ORB descriptor core. Captures each 256-bit rBRIEF descriptor the core emits, tags it with the raster position (column, row) of the pixel cycle in which it was produced, and buffers it in a small FIFO. It then serializes each entry onto a 32-bit valid/ready stream as a 9-word packet for the host/DMA interface. Because the input side is not back-pressured, the block drops descriptors on overflow and records the loss.

## Interface
- IMG_WIDTH, 640, pixels per row; column counter range 0..IMG_WIDTH-1
- IMG_HEIGHT, 480, rows per frame; row counter range 0..IMG_HEIGHT-1
- WIDTH_DESCRIPTORS, 256, descriptor width; fixed at 8 × 32
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- ena  input  1  pixel-stream enable, the same ena that drives the descriptor core
- descriptors  input  256  descriptor from the core
- in_valid  input  1  core's out_valid; sampled only when ena=1
- out_data  output  32  packet word
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts the word
- out_last  output  1  high on the final (9th) word of a packet
- overflow  output  1  sticky; set when a descriptor is dropped
- drop_count  output  16  saturating drop counter (see Configuration)

## Operation
- Raster counters col and row reset to 0. On each ena=1 cycle, col increments. At IMG_WIDTH-1, col wraps to 0 and row increments. row wraps from IMG_HEIGHT-1 to 0.
- Push when ena && in_valid && !full. The entry stores {row[15:0], col[15:0]} as sampled in that same cycle, before the increment, plus the descriptor.
- ena && in_valid && full drops the descriptor, sets overflow, and increments drop_count. The tag counters still advance.
- Full and empty are evaluated from the start-of-cycle occupancy. A pop in the same cycle does not free a slot for a push, so there is no pass-through when full. A push and a pop in the same cycle when neither full nor empty leaves occupancy unchanged.
- Output FSM:
  - IDLE: out_valid=0. If FIFO is non-empty, load the head entry into the output register and go to HDR.
  - HDR: out_data={row,col}. On out_valid && out_ready, go to BODY with idx=0.
  - BODY: out_data=descriptors[32*idx+31:32*idx], sent LSW first. Each handshake increments idx. At idx=7 the handshake pops the FIFO head and goes to IDLE.
- out_last=1 only in BODY with idx=7.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- ena=0 does not stall the output side.
- overflow clears only on reset.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, overflow=0, drop_count=0, FSM=IDLE, FIFO empty, col=row=0.
- Reset asserted mid-packet aborts the packet. The FIFO contents are discarded.
- Push at edge N gives the header on out_data with out_valid=1 from edge N+1 (IDLE→HDR load).
- With out_ready held high, a packet takes 9 consecutive cycles. The next packet's header appears 1 cycle after out_last, because of the IDLE load cycle. Sustained rate is one descriptor per 10 cycles.
- out_valid, out_data and out_last are driven directly from registers, with no combinational path from out_ready.

## Configuration
- ORB_PACKER_STATS_EN defined: drop_count is a 16-bit counter that increments once per dropped descriptor and saturates at 16'hFFFF.
- ORB_PACKER_STATS_EN undefined: the counter logic is not compiled and drop_count is tied to 0. The overflow flag works in both cases.

## Test plan
- Single descriptor: reset, ena=1, one in_valid at col=5, row=0 with descriptors=256'h…0807060504030201 pattern, out_ready=1. Response: header 32'h0000_0005 one cycle later, then 8 words LSW first, out_last on the 9th word only, then out_valid=0.
- Raster wrap: drive IMG_WIDTH+3 ena cycles, then in_valid. Response: header {row=1, col=3}. At end of frame, row wraps to 0.
- Back-pressure: toggle out_ready pseudo-randomly while 3 descriptors are queued. Response: all 27 words are delivered in order with data held stable during stalls.
- Overflow: out_ready=0, push DEPTH+2 descriptors. Response: first DEPTH accepted, overflow=1, drop_count=2 (0 without ORB_PACKER_STATS_EN). Release out_ready and only DEPTH packets emerge.
- Full with simultaneous pop: FIFO full, last BODY handshake and in_valid in the same cycle. Response: the incoming descriptor is dropped and occupancy goes to DEPTH-1.
- ena gating: in_valid=1 with ena=0. Response: no push, and counters do not advance.
